// File: rtl/lcrc_32.sv
// Link CRC-32 generator: registers {data, ~crc32(data)} with one cycle of latency.
// Define LCRC_32_ACCUM_EN to accumulate the CRC across words until the next reset.
module lcrc_32 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  in,
  input  logic              reset,
  input  logic              clk,
  output logic [WIDTH+31:0] final_out
);

  localparam logic [31:0] POLY_R    = 32'hEDB88320;
  localparam logic [31:0] CRC_SEED  = 32'hFFFFFFFF;

  // Reflected CRC-32 over the whole word, unrolled; bit i of in is the i-th bit on the wire,
  // which gives byte 0 first and LSB-first within each byte.
  function automatic logic [31:0] crc_update(input logic [31:0] seed,
                                             input logic [WIDTH-1:0] data);
    logic [31:0] c;
    c = seed;
    for (int i = 0; i < WIDTH; i++) begin
      c = (c >> 1) ^ (((c[0] ^ data[i]) == 1'b1) ? POLY_R : 32'h0);
    end
    return c;
  endfunction

  logic [31:0]       seed_p0;
  logic [31:0]       crc_p0;
  logic [WIDTH+31:0] out_p1;

`ifdef LCRC_32_ACCUM_EN
  logic [31:0] seed_p1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      seed_p1 <= CRC_SEED;
    end else begin
      seed_p1 <= crc_p0;
    end
  end

  assign seed_p0 = seed_p1;
`else
  assign seed_p0 = CRC_SEED;
`endif

  assign crc_p0 = crc_update(seed_p0, in);

  // ---- stage p0 -> p1: output register ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_p1 <= '0;
    end else begin
      out_p1 <= {in, ~crc_p0};
    end
  end

  assign final_out = out_p1;

endmodule

// File: tb/tb_lcrc_32.sv
// Bench for lcrc_32: table-driven bytewise CRC-32 model checked every cycle against
// WIDTH=8 and WIDTH=16 instances, plus literal zlib values.
module tb_lcrc_32;

  logic        clk;
  logic        reset;
  logic [7:0]  in8;
  logic [15:0] in16;
  logic [39:0] out8;
  logic [47:0] out16;

  int checks = 0;
  int errors = 0;

  logic [31:0] crc_tbl [256];

  lcrc_32 #(.WIDTH(8)) dut8 (
    .in(in8), .reset(reset), .clk(clk), .final_out(out8)
  );

  lcrc_32 #(.WIDTH(16)) dut16 (
    .in(in16), .reset(reset), .clk(clk), .final_out(out16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Uncomplemented running CRC over the low nbytes of w, first byte in w[7:0].
  function automatic logic [31:0] word_crc(input logic [31:0] seed, input logic [15:0] w,
                                           input int nbytes);
    logic [31:0] c;
    logic [7:0]  b;
    c = seed;
    for (int j = 0; j < nbytes; j++) begin
      b = w[8*j +: 8];
      c = (c >> 8) ^ crc_tbl[c[7:0] ^ b];
    end
    return c;
  endfunction

  task automatic cmp(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: expected registered output and per-width running seed.
  logic [31:0] s8, s16;
  logic [39:0] e8;
  logic [47:0] e16;
  logic        ev = 1'b0;

  always @(posedge clk) begin
    ev <= 1'b1;
    if (!reset) begin
      e8  <= '0;
      e16 <= '0;
      s8  <= 32'hFFFFFFFF;
      s16 <= 32'hFFFFFFFF;
    end else begin
      e8  <= {in8, ~word_crc(s8, {8'h00, in8}, 1)};
      e16 <= {in16, ~word_crc(s16, in16, 2)};
`ifdef LCRC_32_ACCUM_EN
      s8  <= word_crc(s8, {8'h00, in8}, 1);
      s16 <= word_crc(s16, in16, 2);
`endif
    end
  end

  always @(negedge clk) begin
    if (ev) begin
      cmp("out8_model", {8'h00, out8}, {8'h00, e8});
      cmp("out16_model", out16, e16);
    end
  end

  task automatic step(input logic r, input logic [7:0] a, input logic [15:0] b);
    reset = r;
    in8   = a;
    in16  = b;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] c;
    logic [31:0] v;

    reset = 1'b0;
    in8   = 8'h55;
    in16  = 16'h5555;

    for (int k = 0; k < 256; k++) begin
      v = 32'(k);
      for (int b = 0; b < 8; b++) begin
        v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
      end
      crc_tbl[k] = v;
    end

    // Pin the model to known zlib values.
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) c = word_crc(c, 16'(8'h31 + i), 1);
    cmp("model_123456789", {16'h0, ~c}, {16'h0, 32'hCBF43926});
    cmp("model_55", {16'h0, ~word_crc(32'hFFFFFFFF, 16'h0055, 1)}, {16'h0, 32'hC9034AF6});
    cmp("model_00", {16'h0, ~word_crc(32'hFFFFFFFF, 16'h0000, 1)}, {16'h0, 32'hD202EF8D});
    cmp("model_61", {16'h0, ~word_crc(32'hFFFFFFFF, 16'h0061, 1)}, {16'h0, 32'hE8B7BE43});

    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h55, 16'h5555);
      cmp("reset_hold8", {8'h00, out8}, 48'h0);
      cmp("reset_hold16", out16, 48'h0);
    end

`ifndef LCRC_32_ACCUM_EN
    step(1'b1, 8'h55, 16'h5555);
    cmp("word_55", {8'h00, out8}, {8'h00, 40'h55_C9034AF6});
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h55, 16'h5555);
      cmp("word_55_stable", {8'h00, out8}, {8'h00, 40'h55_C9034AF6});
    end
    step(1'b1, 8'h00, 16'h0000);
    cmp("word_00", {8'h00, out8}, {8'h00, 40'h00_D202EF8D});
    step(1'b1, 8'h61, 16'h0061);
    cmp("word_61", {8'h00, out8}, {8'h00, 40'h61_E8B7BE43});
`endif

    step(1'b0, 8'hAA, 16'hAAAA);
    cmp("mid_reset8", {8'h00, out8}, 48'h0);
    cmp("mid_reset16", out16, 48'h0);

`ifndef LCRC_32_ACCUM_EN
    step(1'b1, 8'h61, 16'h0061);
    cmp("post_reset_61", {8'h00, out8}, {8'h00, 40'h61_E8B7BE43});
`else
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h31 + i), 16'h0000);
    cmp("accum_123456789", {16'h0, out8[31:0]}, {16'h0, 32'hCBF43926});
    step(1'b0, 8'h00, 16'h0000);
    step(1'b1, 8'h55, 16'h5555);
    cmp("accum_restart_55", {16'h0, out8[31:0]}, {16'h0, 32'hC9034AF6});
`endif

    step(1'b1, 8'h55, 16'h5555);
    cmp("w16_data", {32'h0, out16[47:32]}, {32'h0, 16'h5555});

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 15) != 0), 8'($urandom), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
